tree_walk_controller: RTL and testbench
=======================================

// Module: tree_walk_controller
// PURPOSE
//  Sequences one decision-tree inference: accepts a feature vector, walks node memory
//  from ROOT_ADDR, and follows the left/right child links until a leaf is reached.
//  Each fetched 64-bit node word is decoded with the standard node field layout.
//  Returns the leaf class, or an error flag if the walk runs too deep.
//  Sits between the CAN feature extractor (upstream) and the result/alert logic
//  (downstream), and owns the read port of the node ROM/RAM.
// PARAMETERS
//  FEAT_W     27  width of each feature and of the threshold field
//  NUM_FEAT   8   number of features; feature_id is 3 bits
//  ROOT_ADDR  0   node address of the tree root
//  MAX_DEPTH  32  maximum nodes visited before the walk is aborted with an error
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  in_valid     in   1               feature vector valid
//  in_ready     out  1               controller can accept a vector
//  in_features  in   NUM_FEAT*FEAT_W feature k at bits [k*FEAT_W +: FEAT_W]
//  mem_en       out  1               node memory read strobe
//  mem_addr     out  8               node address
//  mem_rdata    in   64              node word; valid the cycle after mem_en (1-cycle sync read)
//  out_valid    out  1               result valid
//  out_ready    in   1               downstream accepts result
//  out_class    out  8               leaf class = node threshold[7:0] (node_data[33:26])
//  out_err      out  1               depth limit hit; out_class=0 when set
//  out_depth    out  6               number of nodes visited, including the leaf
//  busy         out  1               high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, mem_en=0, mem_addr=ROOT_ADDR, out_valid=0,
//   out_class=0, out_err=0, out_depth=0, busy=0. Reset is async at any time, including mid-walk.
//   An in-flight walk is dropped; a held result is lost.
//  Node decode: feature_id=[55:53], threshold=[52:26], right=[25:18], left=[17:10], type=[9:2].
//   leaf = (type==8'h01) || (left==0 && right==0).
//  FSM:
//   IDLE : in_ready=1. On in_valid: latch features, addr<=ROOT_ADDR, depth<=0, go to FETCH.
//   FETCH: mem_en=1 for exactly one cycle with mem_addr=addr, then WAIT.
//   WAIT : register mem_rdata into node_q, depth<=depth+1, go to EVAL.
//   EVAL : If leaf: class<=threshold[7:0], err<=0, go to DONE.
//          Else if depth==MAX_DEPTH: err<=1, class<=0, go to DONE.
//          Else: unsigned compare feature[feature_id] <= threshold.
//            True  -> addr<=left.
//            False -> addr<=right.
//          Then go to FETCH.
//   DONE : out_valid=1; out_class/out_err/out_depth stay stable.
//          On out_ready: go to IDLE; out_valid drops next cycle.
//  Timing: 3 cycles per node. For a walk of n nodes, out_valid rises 3n+1 cycles after
//   the input handshake edge. A root leaf gives 4 cycles.
//  in_ready is low outside IDLE. in_valid while busy is ignored (not queued).
//   No new vector is accepted in the DONE->IDLE transition cycle.
//  Result hold: out_valid with out_ready=0 holds indefinitely.
//  feature_id values >= NUM_FEAT select feature 0.
//  A child pointer equal to the current address (self-loop) is not special-cased;
//   it terminates through the MAX_DEPTH error path.
//  mem_en is never high in IDLE, WAIT, EVAL or DONE.
// TESTING
//  T1 Root leaf: node0 type=01, thr[7:0]=8'h05 -> out_valid 4 cycles after accept,
//     class=5, err=0, depth=1.
//  T2 Two-level walk: node0 f=2, thr=100 (left=1, right=2); f2=100 ->
//     addresses 0 then 1 read; class = node1 class; depth=2; latency 7 cycles.
//     Repeat with f2=101 -> node2 read.
//  T3 Boundary compare: threshold=27'h7FFFFFF, feature=27'h7FFFFFF -> left;
//     threshold=0, feature=1 -> right.
//  T4 Self-loop at node0 (left=right=0 but type!=01 is a leaf, so use left=right=3
//     at addr 3) -> err=1, class=0, depth=MAX_DEPTH.
//  T5 Backpressure: out_ready low for 10 cycles -> outputs stable, in_ready=0,
//     extra in_valid ignored; after out_ready pulse, next vector is accepted.
//  T6 rst_n low during WAIT -> all outputs at reset values immediately;
//     a new walk after reset completes correctly.

Source files
------------

// File: rtl/tree_walk_controller.sv
// Decision-tree inference sequencer: walks node memory from the root, comparing one
// feature per node against its threshold, until a leaf or the depth limit is reached.
module tree_walk_controller #(
  parameter int         FEAT_W    = 27,
  parameter int         NUM_FEAT  = 8,
  parameter logic [7:0] ROOT_ADDR = 8'd0,
  parameter int         MAX_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0] in_features,
  output logic                       mem_en,
  output logic [7:0]                 mem_addr,
  input  logic [63:0]                mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_class,
  output logic                       out_err,
  output logic [5:0]                 out_depth,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      state;
  logic [NUM_FEAT*FEAT_W-1:0]  feats;
  logic [55:2]                 node_q;
  logic [5:0]                  depth;

  logic [2:0]        fid;
  logic [FEAT_W-1:0] thr;
  logic [7:0]        right_ptr;
  logic [7:0]        left_ptr;
  logic [7:0]        node_type;
  logic              is_leaf;
  logic [FEAT_W-1:0] sel;
  logic              go_left;
  logic              unused_rdata;

  assign fid       = node_q[55:53];
  assign thr       = node_q[26 +: FEAT_W];
  assign right_ptr = node_q[25:18];
  assign left_ptr  = node_q[17:10];
  assign node_type = node_q[9:2];
  assign is_leaf   = (node_type == 8'h01) || (left_ptr == 8'h00 && right_ptr == 8'h00);
  assign unused_rdata = ^{mem_rdata[63:56], mem_rdata[1:0]};

  // Out-of-range feature ids fall back to feature 0.
  always_comb begin
    sel = feats[FEAT_W-1:0];
    for (int k = 1; k < NUM_FEAT; k++) begin
      if (fid == 3'(k)) sel = feats[k*FEAT_W +: FEAT_W];
    end
  end

  assign go_left = (sel <= thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      mem_en    <= 1'b0;
      mem_addr  <= ROOT_ADDR;
      out_valid <= 1'b0;
      out_class <= 8'h00;
      out_err   <= 1'b0;
      out_depth <= 6'd0;
      busy      <= 1'b0;
      feats     <= '0;
      node_q    <= '0;
      depth     <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            feats    <= in_features;
            mem_addr <= ROOT_ADDR;
            depth    <= 6'd0;
            mem_en   <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_en <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          node_q <= mem_rdata[55:2];
          depth  <= depth + 6'd1;
          state  <= S_EVAL;
        end
        S_EVAL: begin
          if (is_leaf) begin
            out_class <= node_q[33:26];
            out_err   <= 1'b0;
            out_depth <= depth;
            state     <= S_DONE;
          end else if (depth == 6'(MAX_DEPTH)) begin
            out_class <= 8'h00;
            out_err   <= 1'b1;
            out_depth <= depth;
            state     <= S_DONE;
          end else begin
            mem_addr <= go_left ? left_ptr : right_ptr;
            mem_en   <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          // First DONE cycle raises out_valid; out_ready only counts once it is visible.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          mem_en   <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_walk_controller.sv
// Testbench for tree_walk_controller: node memory model, walk reference model,
// directed scenarios and randomized trees.
module tb_tree_walk_controller;
  localparam int FEAT_W    = 27;
  localparam int NUM_FEAT  = 8;
  localparam int MAX_DEPTH = 32;
  localparam int FW        = FEAT_W * NUM_FEAT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_features = '0;
  logic          mem_en;
  logic [7:0]    mem_addr;
  logic [63:0]   mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_class;
  logic          out_err;
  logic [5:0]    out_depth;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tree_walk_controller #(.FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT), .ROOT_ADDR(8'd0), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_err(out_err), .out_depth(out_depth), .busy(busy)
  );

  logic [63:0] mem [256];
  logic [7:0]  rd_q [$];
  logic [7:0]  exp_q [$];
  int          viol = 0;
  logic        prev_en = 1'b0;

  // Synchronous-read node memory plus protocol monitor.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
    if (rst_n)
      viol <= viol + int'(mem_en && prev_en) + int'(mem_en && !busy) + int'(out_valid && in_ready);
    prev_en <= rst_n ? mem_en : 1'b0;
  end

  // Reference model results
  logic [7:0] m_class;
  logic       m_err;
  int         m_depth;

  // Walk observations
  logic [7:0] o_class;
  logic       o_err;
  logic [5:0] o_depth;
  int         o_lat;
  bit         timed_out;

  function automatic logic [63:0] mk(input logic [7:0] typ, input logic [2:0] fid,
                                     input logic [26:0] thr, input logic [7:0] l, input logic [7:0] r);
    return {8'h00, fid, thr, r, l, typ, 2'b00};
  endfunction

  function automatic logic [FW-1:0] rand_vec();
    logic [FW-1:0] v;
    for (int j = 0; j < NUM_FEAT; j++) v[j*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
    return v;
  endfunction

  function automatic bit addrs_match();
    if (rd_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (rd_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
  endtask

  task automatic model_walk(input logic [FW-1:0] f);
    logic [7:0]  a;
    logic [63:0] w;
    logic [26:0] fv;
    int          fid;
    bit          done;
    exp_q.delete();
    a = 8'h00;
    m_depth = 0;
    done = 1'b0;
    while (!done) begin
      exp_q.push_back(a);
      w = mem[a];
      m_depth++;
      if (w[9:2] == 8'h01 || (w[17:10] == 8'h00 && w[25:18] == 8'h00)) begin
        m_class = w[33:26]; m_err = 1'b0; done = 1'b1;
      end else if (m_depth == MAX_DEPTH) begin
        m_class = 8'h00; m_err = 1'b1; done = 1'b1;
      end else begin
        fid = int'(w[55:53]);
        if (fid >= NUM_FEAT) fid = 0;
        fv = f[fid*FEAT_W +: FEAT_W];
        a = (fv <= w[52:26]) ? w[17:10] : w[25:18];
      end
    end
  endtask

  // Hands one vector to the DUT and waits for the result; hold=1 leaves it un-acknowledged.
  task automatic run_walk(input logic [FW-1:0] f, input bit hold);
    int k;
    timed_out = 1'b0;
    rd_q.delete();
    @(negedge clk);
    in_features = f;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin timed_out = 1'b1; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    o_lat = 0;
    while (!out_valid && o_lat < 200) begin @(posedge clk); #1; o_lat++; end
    if (!out_valid) begin timed_out = 1'b1; return; end
    o_class = out_class; o_err = out_err; o_depth = out_depth;
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({in_ready, mem_en, out_valid, busy, out_err} !== 5'b10000) begin errors++;
      $display("FAIL reset_flags: got %b expected 10000", {in_ready, mem_en, out_valid, busy, out_err}); end
    checks++; if ({mem_addr, out_class, out_depth} !== 22'h0) begin errors++;
      $display("FAIL reset_values: addr=%0h class=%0h depth=%0d expected all 0", mem_addr, out_class, out_depth); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_root_leaf();
    logic [FW-1:0] f;
    clear_mem();
    mem[0] = mk(8'h01, 3'd0, 27'h0000005, 8'd7, 8'd9);
    f = rand_vec();
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL root_timeout: got %0d expected 0", timed_out); end
    checks++; if ({o_class, o_err, o_depth} !== {8'h05, 1'b0, 6'd1}) begin errors++;
      $display("FAIL root_result: got class=%0h err=%0d depth=%0d expected 5 0 1", o_class, o_err, o_depth); end
    checks++; if (o_lat != 4) begin errors++; $display("FAIL root_latency: got %0d expected 4", o_lat); end
  endtask

  task automatic test_two_level();
    logic [FW-1:0] f;
    clear_mem();
    mem[0] = mk(8'h00, 3'd2, 27'd100, 8'd1, 8'd2);
    mem[1] = mk(8'h01, 3'd0, 27'h0000011, 8'd0, 8'd0);
    mem[2] = mk(8'h01, 3'd0, 27'h0000022, 8'd0, 8'd0);
    for (int v = 100; v <= 101; v++) begin
      f = rand_vec();
      f[2*FEAT_W +: FEAT_W] = FEAT_W'(v);
      run_walk(f, 1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL two_timeout: f2=%0d got timeout", v); end
      checks++; if ({o_class, o_err, o_depth} !== {(v == 100) ? 8'h11 : 8'h22, 1'b0, 6'd2}) begin errors++;
        $display("FAIL two_result: f2=%0d got class=%0h err=%0d depth=%0d expected %0h 0 2",
                 v, o_class, o_err, o_depth, (v == 100) ? 8'h11 : 8'h22); end
      checks++; if (o_lat != 7) begin errors++; $display("FAIL two_latency: got %0d expected 7", o_lat); end
      checks++; if (rd_q.size() != 2 || rd_q[0] !== 8'd0 || rd_q[1] !== ((v == 100) ? 8'd1 : 8'd2)) begin errors++;
        $display("FAIL two_addrs: got %0d reads expected 0 then %0d", rd_q.size(), (v == 100) ? 1 : 2); end
    end
  endtask

  task automatic test_boundary();
    logic [FW-1:0] f;
    clear_mem();
    mem[1] = mk(8'h01, 3'd0, 27'h00000A1, 8'd0, 8'd0);
    mem[2] = mk(8'h01, 3'd0, 27'h00000B2, 8'd0, 8'd0);
    mem[0] = mk(8'h00, 3'd4, 27'h7FFFFFF, 8'd1, 8'd2);
    f = rand_vec(); f[4*FEAT_W +: FEAT_W] = 27'h7FFFFFF;
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0 || o_class !== 8'hA1) begin errors++;
      $display("FAIL bound_max_left: got class=%0h timeout=%0d expected a1", o_class, timed_out); end
    mem[0] = mk(8'h00, 3'd7, 27'h0, 8'd1, 8'd2);
    f = rand_vec(); f[7*FEAT_W +: FEAT_W] = 27'd1;
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0 || o_class !== 8'hB2) begin errors++;
      $display("FAIL bound_zero_right: got class=%0h timeout=%0d expected b2", o_class, timed_out); end
  endtask

  task automatic test_self_loop();
    logic [FW-1:0] f;
    clear_mem();
    mem[0] = mk(8'h00, 3'd1, 27'h1234, 8'd3, 8'd3);
    mem[3] = mk(8'h00, 3'd5, 27'h00000AB, 8'd3, 8'd3);
    f = rand_vec();
    model_walk(f);
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0 || {o_class, o_err, o_depth} !== {8'h00, 1'b1, 6'd32}) begin errors++;
      $display("FAIL loop_result: got class=%0h err=%0d depth=%0d expected 0 1 32", o_class, o_err, o_depth); end
    checks++; if (o_lat != 97) begin errors++; $display("FAIL loop_latency: got %0d expected 97", o_lat); end
    checks++; if (!addrs_match()) begin errors++;
      $display("FAIL loop_addrs: got %0d reads expected %0d", rd_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f;
    int nreads;
    bit stable;
    clear_mem();
    mem[0] = mk(8'h00, 3'd3, 27'd500, 8'd4, 8'd5);
    mem[4] = mk(8'h01, 3'd0, 27'h0000044, 8'd0, 8'd0);
    mem[5] = mk(8'h01, 3'd0, 27'h0000055, 8'd0, 8'd0);
    f = rand_vec(); f[3*FEAT_W +: FEAT_W] = 27'd10;
    run_walk(f, 1'b1);
    checks++; if (timed_out !== 1'b0 || o_class !== 8'h44 || o_depth !== 6'd2) begin errors++;
      $display("FAIL bp_result: got class=%0h depth=%0d expected 44 2", o_class, o_depth); end
    nreads = rd_q.size();
    in_features = rand_vec();
    in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          out_class !== 8'h44 || out_err !== 1'b0 || out_depth !== 6'd2) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++;
      $display("FAIL bp_hold: got unstable outputs (valid=%0d ready=%0d class=%0h) expected held", out_valid, in_ready, out_class); end
    checks++; if (rd_q.size() != nreads) begin errors++;
      $display("FAIL bp_ignored: got %0d reads expected %0d", rd_q.size(), nreads); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin errors++;
      $display("FAIL bp_release: got valid/ready/busy=%b expected 010", {out_valid, in_ready, busy}); end
    f[3*FEAT_W +: FEAT_W] = 27'd501;
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0 || o_class !== 8'h55) begin errors++;
      $display("FAIL bp_next: got class=%0h timeout=%0d expected 55", o_class, timed_out); end
  endtask

  task automatic test_reset_mid_walk();
    logic [FW-1:0] f;
    clear_mem();
    mem[0] = mk(8'h00, 3'd6, 27'd50, 8'd8, 8'd9);
    mem[8] = mk(8'h01, 3'd0, 27'h0000088, 8'd0, 8'd0);
    mem[9] = mk(8'h01, 3'd0, 27'h0000099, 8'd0, 8'd0);
    f = rand_vec(); f[6*FEAT_W +: FEAT_W] = 27'd60;
    run_walk(f, 1'b0);
    checks++; if (o_class !== 8'h99) begin errors++; $display("FAIL rst_pre: got class=%0h expected 99", o_class); end
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, mem_en, out_valid, busy, out_err} !== 5'b10000 ||
                  {mem_addr, out_class, out_depth} !== 22'h0) begin errors++;
      $display("FAIL rst_mid: got flags=%b addr=%0h class=%0h depth=%0d expected 10000 0 0 0",
               {in_ready, mem_en, out_valid, busy, out_err}, mem_addr, out_class, out_depth); end
    @(negedge clk); rst_n = 1'b1;
    f[6*FEAT_W +: FEAT_W] = 27'd50;
    run_walk(f, 1'b0);
    checks++; if (timed_out !== 1'b0 || {o_class, o_depth} !== {8'h88, 6'd2} || o_lat != 7) begin errors++;
      $display("FAIL rst_after: got class=%0h depth=%0d lat=%0d expected 88 2 7", o_class, o_depth, o_lat); end
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) begin
        clear_mem();
        for (int i = 0; i < 64; i++)
          mem[i] = mk(($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom_range(2, 255)),
                      3'($urandom), 27'($urandom), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63)));
      end
      f = rand_vec();
      model_walk(f);
      run_walk(f, 1'b0);
      checks++; if (timed_out !== 1'b0 || {o_class, o_err, o_depth} !== {m_class, m_err, 6'(m_depth)}) begin errors++;
        $display("FAIL rand_result[%0d]: got class=%0h err=%0d depth=%0d expected %0h %0d %0d",
                 t, o_class, o_err, o_depth, m_class, m_err, m_depth); end
      checks++; if (o_lat != 3 * m_depth + 1 || !addrs_match()) begin errors++;
        $display("FAIL rand_path[%0d]: got lat=%0d reads=%0d expected lat=%0d reads=%0d",
                 t, o_lat, rd_q.size(), 3 * m_depth + 1, exp_q.size()); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (viol != 0) begin errors++;
      $display("FAIL protocol: got %0d mem_en/handshake violations expected 0", viol); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_root_leaf();
    test_two_level();
    test_boundary();
    test_self_loop();
    test_backpressure();
    test_random();
    test_reset_mid_walk();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
